// File: rtl/sw_mem_pkg.sv
// rtl/sw_mem_pkg.sv - shared geometry and types for the 32x26 2-port SRAM sample buffer
// Purpose: address/data widths of the SRAM macro and the word/address types built on them.
package sw_mem_pkg;

  localparam int SW_AW = 5;
  localparam int SW_DW = 26;

  typedef logic [SW_DW-1:0] sw_word_t;
  typedef logic [SW_AW-1:0] sw_addr_t;

endpackage

// File: rtl/sw_skid2.sv
// rtl/sw_skid2.sv - 2-entry registered skid buffer in FIFO order
// Purpose: catches SRAM read returns so the consumer sees registered data with no latency bubbles.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset (clears count only)
//   i_push, i_data  write one word (caller guarantees a free slot or a same-cycle pop)
//   i_pop           consumer ready; takes effect only while o_valid
//   o_valid         at least one entry held
//   o_data          oldest entry
//   o_cnt           entries held, 0..2
module sw_skid2
  import sw_mem_pkg::*;
#(
  parameter int DW = SW_DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);

  logic [DW-1:0] r_e0;  // oldest
  logic [DW-1:0] r_e1;
  logic [1:0]    r_cnt;
  logic          w_pop;

  assign w_pop   = i_pop & (r_cnt != 2'd0);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_e0;
  assign o_cnt   = r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Oldest leaves, new word lands behind whatever remains.
          if (r_cnt == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end else begin
            r_e0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sw_sram_fifo_ctrl.sv
// rtl/sw_sram_fifo_ctrl.sv - FIFO controller driving an external 32x26 2-port SRAM macro
// Purpose: push/pop valid-ready FIFO over a 1-cycle-latency SRAM; a 2-entry skid hides read latency.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   push_valid/push_data/push_ready write stream (ready while SRAM has a free entry)
//   pop_valid/pop_data/pop_ready    read stream (head word from the skid buffer)
//   level                           registered total words held (SRAM + in-flight + skid)
//   mem_a/mem_csa/mem_web/mem_di    SRAM port A (write)
//   mem_b/mem_csb/mem_oe/mem_do     SRAM port B (read), data returns the cycle after mem_csb
module sw_sram_fifo_ctrl
  import sw_mem_pkg::*;
#(
  parameter int AW = SW_AW,
  parameter int DW = SW_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  input  logic          pop_ready,
  output logic [AW+1:0] level,
  output logic [AW-1:0] mem_a,
  output logic          mem_csa,
  output logic          mem_web,
  output logic [DW-1:0] mem_di,
  output logic [AW-1:0] mem_b,
  output logic          mem_csb,
  output logic          mem_oe,
  input  logic [DW-1:0] mem_do
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_mem_cnt;   // one extra bit so full and empty are distinct
  logic          r_inflight;  // read issued last cycle, data on mem_do now
  logic [AW+1:0] r_level;

  logic          w_wr;
  logic          w_rd;
  logic          w_pop_fire;
  logic [1:0]    w_skid_cnt;
  logic [AW:0]   w_mem_cnt_nxt;
  logic [1:0]    w_skid_cnt_nxt;

  assign push_ready = rst_n & (r_mem_cnt != FULL_CNT);
  assign w_wr       = push_valid & push_ready;
  assign w_pop_fire = pop_valid & pop_ready;

  // Issue a read only if the skid will still have room when the data returns,
  // counting the word already in flight and a pop leaving this cycle.
  assign w_rd = rst_n & (r_mem_cnt != '0) &
                (({1'b0, w_skid_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop_fire}));

  assign mem_a   = r_wptr;
  assign mem_csa = w_wr;
  assign mem_web = ~w_wr;
  assign mem_di  = push_data;
  assign mem_b   = r_rptr;
  assign mem_csb = w_rd;
  assign mem_oe  = rst_n;
  assign level   = r_level;

  assign w_mem_cnt_nxt  = r_mem_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
  assign w_skid_cnt_nxt = w_skid_cnt + 2'(r_inflight) - 2'(w_pop_fire);

  sw_skid2 #(.DW(DW)) u_skid (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (r_inflight),
    .i_data  (mem_do),
    .i_pop   (pop_ready),
    .o_valid (pop_valid),
    .o_data  (pop_data),
    .o_cnt   (w_skid_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_level    <= '0;
    end else begin
      r_wptr     <= r_wptr + AW'(w_wr);
      r_rptr     <= r_rptr + AW'(w_rd);
      r_mem_cnt  <= w_mem_cnt_nxt;
      r_inflight <= w_rd;
      r_level    <= (AW+2)'(w_mem_cnt_nxt) + (AW+2)'(w_rd) + (AW+2)'(w_skid_cnt_nxt);
    end
  end

endmodule
